// File: rtl/lcd_spi_writer.sv
// lcd_spi_writer: serializes one 9-bit {dc, byte} word per accepted request onto
// a 4-wire SPI LCD bus (CPOL=0, CPHA=0, MSB first) and pulses wr_done when the
// byte is finished and chip select has been released.
module lcd_spi_writer #(
  parameter int CLK_DIV = 2  // lcd_sclk half-period in system clock cycles, 1..255
) (
  input  logic       sys_clk_50MHz,
  input  logic       sys_rst_n,
  input  logic [8:0] data,
  input  logic       en_write,
  output logic       busy,
  output logic       wr_done,
  output logic       lcd_cs_n,
  output logic       lcd_sclk,
  output logic       lcd_mosi,
  output logic       lcd_dc
);

  // Last count value of a phase; the divider counts 0..CLK_DIV-1 in every phase.
  localparam logic [7:0] LP_DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    HOLD     = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t     r_state;
  logic [7:0] r_shift;
  logic [2:0] r_bit;
  logic [7:0] r_div;
  logic       r_cs_n;
  logic       r_sclk;
  logic       r_mosi;
  logic       r_dc;
  logic       r_busy;
  logic       r_wr_done;

  state_t     w_state_next;
  logic [7:0] w_shift_next;
  logic [2:0] w_bit_next;
  logic [7:0] w_div_next;
  logic       w_cs_n_next;
  logic       w_sclk_next;
  logic       w_mosi_next;
  logic       w_dc_next;
  logic       w_busy_next;
  logic       w_wr_done_next;
  logic       w_div_last;

  assign w_div_last = (r_div == LP_DIV_LAST);

  // State and all bus outputs are registered; reset returns the bus to idle at once.
  always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= IDLE;
      r_shift   <= 8'd0;
      r_bit     <= 3'd0;
      r_div     <= 8'd0;
      r_cs_n    <= 1'b1;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_dc      <= 1'b0;
      r_busy    <= 1'b0;
      r_wr_done <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit     <= w_bit_next;
      r_div     <= w_div_next;
      r_cs_n    <= w_cs_n_next;
      r_sclk    <= w_sclk_next;
      r_mosi    <= w_mosi_next;
      r_dc      <= w_dc_next;
      r_busy    <= w_busy_next;
      r_wr_done <= w_wr_done_next;
    end
  end

  // Next-state and next-output decode; the divider reloads on every phase change.
  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_next     = r_bit;
    w_div_next     = r_div + 8'd1;
    w_cs_n_next    = r_cs_n;
    w_sclk_next    = r_sclk;
    w_mosi_next    = r_mosi;
    w_dc_next      = r_dc;
    w_busy_next    = r_busy;
    w_wr_done_next = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_div_next  = 8'd0;
        w_cs_n_next = 1'b1;
        w_sclk_next = 1'b0;
        w_busy_next = 1'b0;
        if (en_write) begin
          // Shadow the request so later changes on data cannot disturb this byte.
          w_shift_next = data[7:0];
          w_dc_next    = data[8];
          w_mosi_next  = data[7];
          w_bit_next   = 3'd7;
          w_cs_n_next  = 1'b0;
          w_busy_next  = 1'b1;
          w_state_next = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (w_div_last) begin
          w_div_next   = 8'd0;
          w_sclk_next  = 1'b1;
          w_state_next = SHIFT_HI;
        end
      end
      SHIFT_HI: begin
        if (w_div_last) begin
          w_div_next  = 8'd0;
          w_sclk_next = 1'b0;
          if (r_bit == 3'd0) begin
            w_state_next = HOLD;
          end else begin
            // Next bit goes out on the same edge that lcd_sclk falls.
            w_bit_next   = r_bit - 3'd1;
            w_shift_next = {r_shift[6:0], 1'b0};
            w_mosi_next  = r_shift[6];
            w_state_next = SHIFT_LO;
          end
        end
      end
      HOLD: begin
        if (w_div_last) begin
          w_div_next     = 8'd0;
          w_cs_n_next    = 1'b1;
          w_wr_done_next = 1'b1;
          w_state_next   = DONE;
        end
      end
      DONE: begin
        w_div_next   = 8'd0;
        w_busy_next  = 1'b0;
        w_state_next = IDLE;
      end
      default: begin
        w_div_next   = 8'd0;
        w_state_next = IDLE;
      end
    endcase
  end

  assign busy     = r_busy;
  assign wr_done  = r_wr_done;
  assign lcd_cs_n = r_cs_n;
  assign lcd_sclk = r_sclk;
  assign lcd_mosi = r_mosi;
  assign lcd_dc   = r_dc;

endmodule

// File: tb/tb_lcd_spi_writer.sv
// tb_lcd_spi_writer: directed checks of lcd_spi_writer at CLK_DIV = 2 and 4.
module tb_lcd_spi_writer;

  logic       clk;
  logic       rst_n;
  logic [8:0] data2, data4;
  logic       en2, en4;
  logic       busy2, done2, cs2, sclk2, mosi2, dc2;
  logic       busy4, done4, cs4, sclk4, mosi4, dc4;
  logic       sel4;

  int n_checks = 0;
  int n_fail   = 0;

  lcd_spi_writer #(.CLK_DIV(2)) dut2 (
    .sys_clk_50MHz(clk), .sys_rst_n(rst_n), .data(data2), .en_write(en2),
    .busy(busy2), .wr_done(done2), .lcd_cs_n(cs2), .lcd_sclk(sclk2),
    .lcd_mosi(mosi2), .lcd_dc(dc2)
  );

  lcd_spi_writer #(.CLK_DIV(4)) dut4 (
    .sys_clk_50MHz(clk), .sys_rst_n(rst_n), .data(data4), .en_write(en4),
    .busy(busy4), .wr_done(done4), .lcd_cs_n(cs4), .lcd_sclk(sclk4),
    .lcd_mosi(mosi4), .lcd_dc(dc4)
  );

  // Observation mux: the directed steps talk to whichever instance sel4 selects.
  wire m_busy = sel4 ? busy4 : busy2;
  wire m_done = sel4 ? done4 : done2;
  wire m_cs_n = sel4 ? cs4   : cs2;
  wire m_sclk = sel4 ? sclk4 : sclk2;
  wire m_mosi = sel4 ? mosi4 : mosi2;
  wire m_dc   = sel4 ? dc4   : dc2;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [8:0] d, input logic en);
    if (sel4) begin data4 = d; en4 = en; end
    else      begin data2 = d; en2 = en; end
  endtask

  // One request issued at a negedge (accept cycle T = k0); monitors cycles T+1 onwards.
  task automatic run_xfer(input logic [8:0] d, input bit use4, input bit inject, input string tag);
    int div;
    int done_k;
    int cs_low, rises, dones, done_at, hi_cnt;
    logic prev_sclk;
    logic [7:0] bits;
    bit dc_ok;
    div = use4 ? 4 : 2;
    done_k = 1 + 17 * div;
    cs_low = 0; rises = 0; dones = 0; done_at = -1; hi_cnt = 0;
    prev_sclk = 1'b0; bits = 8'd0; dc_ok = 1'b1;
    sel4 = use4;
    drive(d, 1'b1);
    for (int k = 1; k <= done_k + 2; k++) begin
      @(negedge clk);
      if (m_cs_n === 1'b0) cs_low++;
      if (m_sclk === 1'b1) hi_cnt++;
      if (prev_sclk === 1'b0 && m_sclk === 1'b1) begin
        bits = {bits[6:0], m_mosi};
        rises++;
      end
      prev_sclk = m_sclk;
      if (m_cs_n === 1'b0 && m_dc !== d[8]) dc_ok = 1'b0;
      if (m_done === 1'b1) begin dones++; done_at = k; end
      if (k == 1) begin
        check({tag, "_busy_t1"}, {31'd0, m_busy}, 32'd1);
        drive(d, 1'b0);
      end
      if (inject) begin
        if (k == 5 || k == done_k) drive(9'h1FF, 1'b1);
        if (k == 6 || k == done_k + 1) drive(9'h1FF, 1'b0);
      end
    end
    check({tag, "_cs_low"},  cs_low,  17 * div);
    check({tag, "_rises"},   rises,   32'd8);
    check({tag, "_bits"},    {24'd0, bits}, {24'd0, d[7:0]});
    check({tag, "_sclk_hi"}, hi_cnt,  8 * div);
    check({tag, "_done_at"}, done_at, done_k);
    check({tag, "_dones"},   dones,   32'd1);
    check({tag, "_dc"},      {31'd0, dc_ok}, 32'd1);
    check({tag, "_end_cs"},  {31'd0, m_cs_n}, 32'd1);
    check({tag, "_end_busy"},{31'd0, m_busy}, 32'd0);
  endtask

  int gaps, gap_bad, hi_run, b2b_dones, b2b_rises, b2b_bitbad, wait_n;
  logic prev_cs, prev_s;
  logic [7:0] b2b_byte;
  bit seen_low;

  initial begin
    rst_n = 1'b1; sel4 = 1'b0;
    data2 = 9'd0; data4 = 9'd0; en2 = 1'b0; en4 = 1'b0;

    // Asynchronous reset asserted between clock edges.
    #3 rst_n = 1'b0;
    #1;
    check("rst_cs_n",  {31'd0, cs2},   32'd1);
    check("rst_sclk",  {31'd0, sclk2}, 32'd0);
    check("rst_mosi",  {31'd0, mosi2}, 32'd0);
    check("rst_dc",    {31'd0, dc2},   32'd0);
    check("rst_busy",  {31'd0, busy2}, 32'd0);
    check("rst_done",  {31'd0, done2}, 32'd0);
    check("rst_cs_n4", {31'd0, cs4},   32'd1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); @(negedge clk);

    // Command byte, data byte, busy rejection.
    run_xfer(9'h02A, 1'b0, 1'b0, "cmd2A");
    @(negedge clk);
    run_xfer(9'h1A5, 1'b1, 1'b0, "dataA5");
    @(negedge clk);
    run_xfer(9'h011, 1'b0, 1'b1, "busy11");
    @(negedge clk);

    // Back-to-back: en_write held high with a fixed word.
    sel4 = 1'b0;
    b2b_byte = 8'h2C;
    gaps = 0; gap_bad = 0; hi_run = 0; b2b_dones = 0; b2b_rises = 0; b2b_bitbad = 0;
    prev_cs = 1'b1; prev_s = 1'b0; seen_low = 1'b0;
    drive(9'h12C, 1'b1);
    for (int k = 1; k <= 110; k++) begin
      @(negedge clk);
      if (cs2 === 1'b1) hi_run++;
      else begin
        if (seen_low && prev_cs === 1'b1) begin
          gaps++;
          if (hi_run != 2) gap_bad++;
        end
        seen_low = 1'b1;
        hi_run = 0;
        if (dc2 !== 1'b1) gap_bad++;
      end
      prev_cs = cs2;
      if (done2 === 1'b1) b2b_dones++;
      if (prev_s === 1'b0 && sclk2 === 1'b1) begin
        if (mosi2 !== b2b_byte[7 - (b2b_rises % 8)]) b2b_bitbad++;
        b2b_rises++;
      end
      prev_s = sclk2;
    end
    drive(9'h12C, 1'b0);
    check("b2b_gaps",    gaps,       32'd3);
    check("b2b_gap_len", gap_bad,    32'd0);
    check("b2b_dones",   b2b_dones,  32'd3);
    check("b2b_rises",   b2b_rises,  32'd24);
    check("b2b_bits",    b2b_bitbad, 32'd0);
    wait_n = 0;
    while (busy2 !== 1'b0 && wait_n < 100) begin @(negedge clk); wait_n++; end
    check("b2b_drain", {31'd0, busy2}, 32'd0);
    @(negedge clk);

    // Reset during the 4th bit (SHIFT_HI of bit index 3 is cycles 15..16 at CLK_DIV=2).
    drive(9'h0F0, 1'b1);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 1) drive(9'h0F0, 1'b0);
    end
    check("mid_pre_sclk", {31'd0, sclk2}, 32'd1);
    check("mid_pre_cs",   {31'd0, cs2},   32'd0);
    #3 rst_n = 1'b0;
    #1;
    check("mid_cs_n", {31'd0, cs2},   32'd1);
    check("mid_sclk", {31'd0, sclk2}, 32'd0);
    check("mid_mosi", {31'd0, mosi2}, 32'd0);
    check("mid_dc",   {31'd0, dc2},   32'd0);
    check("mid_busy", {31'd0, busy2}, 32'd0);
    check("mid_done", {31'd0, done2}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    b2b_dones = 0; gap_bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done2 === 1'b1) b2b_dones++;
      if (cs2 !== 1'b1) gap_bad++;
    end
    check("mid_no_done", b2b_dones, 32'd0);
    check("mid_idle",    gap_bad,   32'd0);
    run_xfer(9'h0C3, 1'b0, 1'b0, "postC3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
